signal_stats: RTL and testbench
===============================

Name: signal_stats

Overview:
- Parametrised successor to the scope front-end magnitude block: per-window min, max, peak-to-peak, midpoint DC offset and true arithmetic mean of ADC samples.
- Sits between the ADC sample stream and the display/trigger logic.
- Adds a sample qualifier, a reset, a power-of-two window, overflow-safe arithmetic, a result-valid strobe and a peak-hold mode.
- Results are published once per window and stay stable between publications.

Parameters:
- DATA_W, 12, sample width in bits (unsigned ADC code).
- LOG2_WIN, 10, window length is 2^LOG2_WIN accepted samples; legal range 1..26.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sample_in  in  DATA_W  unsigned ADC sample.
- sample_valid  in  1  sample_in is accepted on any clk edge where this is high.
- clear  in  1  synchronous window restart; published outputs are kept.
- peak_hold  in  1  when 1, max/min carry across window boundaries.
- max_out  out  DATA_W  largest sample of the published window.
- min_out  out  DATA_W  smallest sample of the published window.
- amplitude  out  DATA_W  max_out - min_out.
- dc_offset  out  DATA_W  (max+min)>>1.
- mean_out  out  DATA_W  sum of window samples >> LOG2_WIN, truncated.
- stats_valid  out  1  one-cycle strobe when new results are published.

Behaviour:
- Reset (rst=1 at clk edge):
  - All outputs go to 0; stats_valid=0.
  - Running max=0, running min=all ones, accumulator=0, sample count=0, FSM to EMPTY.
  - Reset has priority over every other input.
- FSM states:
  - EMPTY: no sample accepted in the current window. A valid sample moves it to ACCUM and loads max=min=sample, acc=sample, count=1. When the window has a single sample, see the publish rule below.
  - ACCUM: each valid sample updates max/min by compare, adds to acc and increments count.
  - When the accepted sample makes count reach 2^LOG2_WIN, that sample is included and the block publishes.
- Publish:
  - Outputs are registered and update on the clk edge after the last sample's acceptance edge, so latency is 1 cycle.
  - stats_valid is high for exactly that one cycle.
  - After publishing, count=0, acc=0 and the FSM returns to EMPTY.
- peak_hold:
  - peak_hold=0: running max/min reset to (0, all ones) at publish.
  - peak_hold=1: running max/min are retained into the next window, and the first sample of the new window is compared, not loaded.
  - peak_hold is sampled at publish time; toggling it mid-window affects only the next boundary.
  - acc and mean are always per-window, independent of peak_hold.
- Arithmetic:
  - amplitude is computed from the final window max/min, which always satisfy max>=min, so it never underflows.
  - dc_offset uses a DATA_W+1 bit sum before the shift; no overflow. Example: 0xFFF + 0xFFE gives 0xFFE.
  - The accumulator is DATA_W+LOG2_WIN bits wide and cannot overflow.
  - mean_out is acc[DATA_W+LOG2_WIN-1:LOG2_WIN].
- clear:
  - Returns to EMPTY, zeroes acc/count, and resets running max/min regardless of peak_hold.
  - Published outputs hold their values; no stats_valid strobe.
  - clear and sample_valid in the same cycle: clear wins and the sample is discarded.
- sample_valid=0: no state change. Gaps of any length inside a window are allowed.
- Between publishes all outputs are constant.
- No output changes on a cycle without stats_valid, except on reset.

Test Plan (LOG2_WIN=2, DATA_W=12):
- Reset, then samples 1,4,2,3 on consecutive cycles -> one cycle after sample 3: stats_valid=1 for one cycle, max=4, min=1, amplitude=3, dc_offset=2, mean=2; outputs hold afterwards.
- Samples 0xFFF,0xFFE,0xFFF,0xFFE with gaps of 3 idle cycles -> max=0xFFF, min=0xFFE, dc_offset=0xFFE, mean=0xFFE, amplitude=1. Checks for no overflow and that gaps are tolerated.
- peak_hold=1: window A = 10,20,30,40, then window B = 25,25,25,25 -> B publishes max=40, min=10, mean=25. Repeat with peak_hold=0 -> B publishes max=25, min=25, amplitude=0.
- Two samples accepted, then clear asserted in the same cycle as a third sample (value 999), then 5,5,5,5 -> the 999 sample is ignored; the next publish gives max=min=mean=5. Outputs from the prior window are unchanged until that publish.
- rst asserted mid-window after 3 samples -> all outputs 0 next cycle. The following 4 samples produce a normal publish with no leftover count.
- Back-to-back windows of 8 continuous samples 0..7 -> stats_valid pulses exactly 2 times, 4 cycles apart. First publish: mean=1, amplitude=3. Second publish: mean=5, amplitude=3.

Source files
------------

// File: rtl/signal_stats.sv
// signal_stats: per-window min/max/peak-to-peak/midpoint/mean of an unsigned ADC stream
module signal_stats #(
  parameter int DATA_W   = 12,
  parameter int LOG2_WIN = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              clear,
  input  logic              peak_hold,
  output logic [DATA_W-1:0] max_out,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] amplitude,
  output logic [DATA_W-1:0] dc_offset,
  output logic [DATA_W-1:0] mean_out,
  output logic              stats_valid
);
  localparam int ACC_W = DATA_W + LOG2_WIN;
  typedef enum logic {EMPTY, ACCUM} state_t;
  state_t                state;
  logic [DATA_W-1:0]     run_max, run_min, nxt_max, nxt_min;
  logic [ACC_W-1:0]      acc, nxt_acc;
  logic [LOG2_WIN-1:0]   cnt;
  logic [DATA_W:0]       mid;
  logic                  last;
  // Running max/min idle at (0, all ones), so comparing the first sample equals loading it.
  always_comb begin
    nxt_max = sample_in > run_max ? sample_in : run_max;
    nxt_min = sample_in < run_min ? sample_in : run_min;
    nxt_acc = (state == EMPTY ? '0 : acc) + ACC_W'(sample_in);
    mid     = {1'b0, nxt_max} + {1'b0, nxt_min};
    last    = &cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      run_max     <= '0;
      run_min     <= '1;
      acc         <= '0;
      cnt         <= '0;
      max_out     <= '0;
      min_out     <= '0;
      amplitude   <= '0;
      dc_offset   <= '0;
      mean_out    <= '0;
      stats_valid <= 1'b0;
    end else begin
      stats_valid <= 1'b0;
      if (clear) begin
        state   <= EMPTY;
        run_max <= '0;
        run_min <= '1;
        acc     <= '0;
        cnt     <= '0;
      end else if (sample_valid) begin
        if (last) begin
          state       <= EMPTY;
          acc         <= '0;
          cnt         <= '0;
          run_max     <= peak_hold ? nxt_max : '0;
          run_min     <= peak_hold ? nxt_min : '1;
          max_out     <= nxt_max;
          min_out     <= nxt_min;
          amplitude   <= nxt_max - nxt_min;
          dc_offset   <= mid[DATA_W:1];
          mean_out    <= nxt_acc[ACC_W-1:LOG2_WIN];
          stats_valid <= 1'b1;
        end else begin
          state   <= ACCUM;
          acc     <= nxt_acc;
          cnt     <= cnt + 1'b1;
          run_max <= nxt_max;
          run_min <= nxt_min;
        end
      end
    end
  end
endmodule

// File: tb/tb_signal_stats.sv
// tb_signal_stats: randomized and directed checks of signal_stats against a window-list model
module tb_signal_stats;
  localparam int DW = 12, LW = 2, WIN = 4;
  logic clk = 0, rst = 0, sample_valid = 0, clear = 0, peak_hold = 0;
  logic [DW-1:0] sample_in = '0;
  logic [DW-1:0] max_out, min_out, amplitude, dc_offset, mean_out;
  logic stats_valid;
  int n_checks = 0, n_fail = 0;
  int q[$];
  bit carry = 0;
  int c_max = 0, c_min = 0;
  int e_max = 0, e_min = 0, e_amp = 0, e_dc = 0, e_mean = 0;
  bit e_sv = 0;

  signal_stats #(.DATA_W(DW), .LOG2_WIN(LW)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .clear(clear), .peak_hold(peak_hold), .max_out(max_out), .min_out(min_out),
    .amplitude(amplitude), .dc_offset(dc_offset), .mean_out(mean_out),
    .stats_valid(stats_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [5*DW:0] act_vec();
    return {max_out, min_out, amplitude, dc_offset, mean_out, stats_valid};
  endfunction

  function automatic logic [5*DW:0] exp_vec();
    return {DW'(e_max), DW'(e_min), DW'(e_amp), DW'(e_dc), DW'(e_mean), e_sv};
  endfunction

  // Drive one clock of inputs and advance the model: the window is a list of
  // accepted samples, reduced to statistics when it holds WIN entries.
  task automatic step(input int s, input bit v, input bit c, input bit r = 0);
    int mx, mn, sum;
    @(negedge clk);
    sample_in = DW'(s); sample_valid = v; clear = c; rst = r;
    @(posedge clk);
    e_sv = 0;
    if (r) begin
      q.delete(); carry = 0;
      e_max = 0; e_min = 0; e_amp = 0; e_dc = 0; e_mean = 0;
    end else if (c) begin
      q.delete(); carry = 0;
    end else if (v) begin
      q.push_back(s);
      if (q.size() == WIN) begin
        mx = carry ? c_max : 0;
        mn = carry ? c_min : (1 << DW) - 1;
        sum = 0;
        foreach (q[i]) begin
          if (q[i] > mx) mx = q[i];
          if (q[i] < mn) mn = q[i];
          sum += q[i];
        end
        e_max = mx; e_min = mn; e_amp = mx - mn; e_dc = (mx + mn) / 2; e_mean = sum / WIN;
        e_sv = 1;
        carry = peak_hold; c_max = mx; c_min = mn;
        q.delete();
      end
    end
    #1;
    rst = 0; clear = 0; sample_valid = 0;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 1);
    n_checks++;
    if (act_vec() !== '0) begin
      n_fail++; $display("FAIL reset: got %h want 0", act_vec());
    end
  endtask

  task automatic test_basic();
    int s[4] = '{1, 4, 2, 3};
    for (int i = 0; i < 4; i++) step(s[i], 1, 0);
    n_checks++;
    if (act_vec() !== {12'd4, 12'd1, 12'd3, 12'd2, 12'd2, 1'b1}) begin
      n_fail++; $display("FAIL basic_publish: got %h want %h", act_vec(), {12'd4, 12'd1, 12'd3, 12'd2, 12'd2, 1'b1});
    end
    step(0, 0, 0);
    step(9, 0, 0);
    n_checks++;
    if (act_vec() !== {12'd4, 12'd1, 12'd3, 12'd2, 12'd2, 1'b0}) begin
      n_fail++; $display("FAIL basic_hold: got %h want %h", act_vec(), {12'd4, 12'd1, 12'd3, 12'd2, 12'd2, 1'b0});
    end
  endtask

  task automatic test_overflow_gaps();
    int s[4] = '{'hFFF, 'hFFE, 'hFFF, 'hFFE};
    for (int i = 0; i < 4; i++) begin
      step(s[i], 1, 0);
      if (i < 3) begin
        for (int g = 0; g < 3; g++) step(0, 0, 0);
        n_checks++;
        if (stats_valid !== 1'b0 || max_out !== 12'd4) begin
          n_fail++; $display("FAIL gap_stable: got sv=%b max=%h want sv=0 max=4", stats_valid, max_out);
        end
      end
    end
    n_checks++;
    if (act_vec() !== {12'hFFF, 12'hFFE, 12'd1, 12'hFFE, 12'hFFE, 1'b1}) begin
      n_fail++; $display("FAIL overflow: got %h want %h", act_vec(), {12'hFFF, 12'hFFE, 12'd1, 12'hFFE, 12'hFFE, 1'b1});
    end
  endtask

  task automatic test_peak_hold();
    int a[4] = '{10, 20, 30, 40};
    for (int p = 1; p >= 0; p--) begin
      peak_hold = p[0];
      step(0, 0, 1);
      for (int i = 0; i < 4; i++) step(a[i], 1, 0);
      for (int i = 0; i < 4; i++) step(25, 1, 0);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL peak_hold_model ph=%0d: got %h want %h", p, act_vec(), exp_vec());
      end
      n_checks++;
      if (p == 1 && {max_out, min_out, mean_out} !== {12'd40, 12'd10, 12'd25}) begin
        n_fail++; $display("FAIL peak_hold_on: got %0d/%0d/%0d want 40/10/25", max_out, min_out, mean_out);
      end else if (p == 0 && {max_out, min_out, amplitude} !== {12'd25, 12'd25, 12'd0}) begin
        n_fail++; $display("FAIL peak_hold_off: got %0d/%0d/%0d want 25/25/0", max_out, min_out, amplitude);
      end
    end
  endtask

  task automatic test_clear();
    logic [5*DW:0] prev;
    peak_hold = 0;
    step(7, 1, 0);
    step(8, 1, 0);
    prev = act_vec();
    step(999, 1, 1);
    n_checks++;
    if (act_vec() !== prev) begin
      n_fail++; $display("FAIL clear_keeps: got %h want %h", act_vec(), prev);
    end
    for (int i = 0; i < 4; i++) begin
      step(5, 1, 0);
      if (i < 3) begin
        n_checks++;
        if (act_vec() !== prev) begin
          n_fail++; $display("FAIL clear_hold%0d: got %h want %h", i, act_vec(), prev);
        end
      end
    end
    n_checks++;
    if (act_vec() !== {12'd5, 12'd5, 12'd0, 12'd5, 12'd5, 1'b1}) begin
      n_fail++; $display("FAIL clear_publish: got %h want %h", act_vec(), {12'd5, 12'd5, 12'd0, 12'd5, 12'd5, 1'b1});
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) step(50 + i, 1, 0);
    step(0, 0, 0, 1);
    n_checks++;
    if (act_vec() !== '0) begin
      n_fail++; $display("FAIL mid_reset: got %h want 0", act_vec());
    end
    for (int i = 1; i <= 4; i++) begin
      step(100 * i, 1, 0);
      n_checks++;
      if (stats_valid !== (i == 4)) begin
        n_fail++; $display("FAIL mid_reset_count%0d: got sv=%b want %b", i, stats_valid, i == 4);
      end
    end
    n_checks++;
    if (act_vec() !== {12'd400, 12'd100, 12'd300, 12'd250, 12'd250, 1'b1}) begin
      n_fail++; $display("FAIL mid_reset_publish: got %h want %h", act_vec(), {12'd400, 12'd100, 12'd300, 12'd250, 12'd250, 1'b1});
    end
  endtask

  task automatic test_back_to_back();
    int pulses[$];
    int want_mean[2] = '{1, 5};
    peak_hold = 0;
    for (int i = 0; i < 10; i++) begin
      step(i < 8 ? i : 0, i < 8, 0);
      if (stats_valid) begin
        pulses.push_back(i);
        n_checks++;
        if (pulses.size() <= 2 && {mean_out, amplitude} !== {12'(want_mean[pulses.size()-1]), 12'd3}) begin
          n_fail++; $display("FAIL b2b_stats%0d: got mean=%0d amp=%0d want %0d/3", pulses.size(), mean_out, amplitude, want_mean[pulses.size()-1]);
        end
      end
    end
    n_checks++;
    if (pulses.size() != 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d want 2", pulses.size());
    end else begin
      n_checks++;
      if (pulses[1] - pulses[0] != 4) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d want 4", pulses[1] - pulses[0]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) peak_hold = ~peak_hold;
      step($urandom_range(0, 4095), $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
           $urandom_range(0, 99) == 0);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random[%0d]: got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow_gaps();
    test_peak_hold();
    test_clear();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
